// File: rtl/scene_buffer_pkg.sv
// Shared types for the scene buffer: instance word, per-word metadata, reader states.
package scene_buffer_pkg;

  localparam int SCENE_MAX_INSTANCES = 64;
  localparam int SCENE_IDX_W = $clog2(SCENE_MAX_INSTANCES + 1);

  typedef logic [SCENE_IDX_W-1:0] scene_idx_t;

  typedef struct packed {
    logic [7:0]  model_id;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
  } modelinstance_t;

  typedef struct packed {
    logic last;
  } modelinstance_meta_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_STREAM
  } rd_state_e;

endpackage

// File: rtl/scene_buffer_if.sv
// Stream bundle for scene_buffer: scene words in from the decoder, instances out to the renderer.
interface scene_buffer_if;
  import scene_buffer_pkg::*;

  logic                scene_in_valid;
  logic                scene_in_ready;
  modelinstance_t      scene_in_data;
  modelinstance_meta_t scene_in_metadata;

  logic                scene_out_valid;
  logic                scene_out_ready;
  modelinstance_t      scene_out_data;
  logic                scene_out_last;

  modport master (
    output scene_in_valid, scene_in_data, scene_in_metadata, scene_out_ready,
    input  scene_in_ready, scene_out_valid, scene_out_data, scene_out_last
  );

  modport slave (
    input  scene_in_valid, scene_in_data, scene_in_metadata, scene_out_ready,
    output scene_in_ready, scene_out_valid, scene_out_data, scene_out_last
  );
endinterface

// File: rtl/scene_bank_ram.sv
// Simple dual-port RAM holding both scene banks; one-cycle registered read with read enable.
module scene_bank_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Output register holds its value while re is low, which keeps stalled output stable.
  always_ff @(posedge clk) begin
    if (!rstn)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/scene_buffer.sv
// Ping-pong scene store: commits scenes from the decoder and streams the newest one per frame_start.
// Optional SCENE_BUFFER_STATS_EN adds committed_count and frame_counter outputs.
module scene_buffer
  import scene_buffer_pkg::*;
#(
  parameter int MAX_INSTANCES = SCENE_MAX_INSTANCES
) (
  input  logic                clk,
  input  logic                rstn,
  scene_buffer_if.slave       bus,
  input  logic                frame_start,
  output logic                frame_done,
  output logic                overflow
`ifdef SCENE_BUFFER_STATS_EN
  ,
  output logic [$clog2(MAX_INSTANCES+1)-1:0] committed_count,
  output logic [15:0]                        frame_counter
`endif
);
  localparam int CW = $clog2(MAX_INSTANCES + 1);
  localparam int AW = $clog2(MAX_INSTANCES);
  localparam int DW = $bits(modelinstance_t);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INSTANCES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  rd_state_e     state_q, state_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] rd_count_q, rd_count_d, pend_count_q, pend_count_d;
  logic          pending_q, pending_d, overflow_q, overflow_d;
  logic          empty_done_q, empty_done_d;

  logic          wr_accept, wr_room, ram_re, out_last, stream_done;
  logic [CW-1:0] wr_ptr_inc, rd_ptr_inc, eff_count;
  logic [AW-1:0] rd_addr_ptr;
  logic [DW-1:0] ram_rdata;

  assign wr_accept  = bus.scene_in_valid && !pending_q;
  assign wr_room    = wr_ptr_q < MAX_CNT;
  assign wr_ptr_inc = wr_ptr_q + ONE;
  assign rd_ptr_inc = rd_ptr_q + ONE;
  assign out_last   = (state_q == R_STREAM) && (rd_ptr_q == rd_count_q - ONE);

  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_count_d   = rd_count_q;
    pend_count_d = pend_count_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    empty_done_d = 1'b0;
    ram_re       = 1'b0;
    rd_addr_ptr  = rd_ptr_q[AW-1:0];
    stream_done  = 1'b0;
    eff_count    = pending_q ? pend_count_q : rd_count_q;

    // Words past capacity are dropped but a dropped last still commits a full bank.
    if (wr_accept) begin
      if (wr_room) wr_ptr_d = wr_ptr_inc;
      else         overflow_d = 1'b1;
      if (bus.scene_in_metadata.last) begin
        pending_d    = 1'b1;
        pend_count_d = wr_room ? wr_ptr_inc : MAX_CNT;
      end
    end

    case (state_q)
      R_IDLE: begin
        if (frame_start) begin
          if (pending_q) begin
            rd_bank_d  = wr_bank_q;
            wr_bank_d  = rd_bank_q;
            rd_count_d = pend_count_q;
            pending_d  = 1'b0;
            wr_ptr_d   = '0;
          end
          if (eff_count == '0) begin
            empty_done_d = 1'b1;
          end else begin
            rd_ptr_d = '0;
            state_d  = R_FETCH;
          end
        end
      end
      R_FETCH: begin
        ram_re  = 1'b1;
        state_d = R_STREAM;
      end
      R_STREAM: begin
        if (bus.scene_out_ready) begin
          if (out_last) begin
            stream_done = 1'b1;
            state_d     = R_IDLE;
          end else begin
            rd_ptr_d    = rd_ptr_inc;
            ram_re      = 1'b1;
            rd_addr_ptr = rd_ptr_inc[AW-1:0];
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= R_IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_count_q   <= '0;
      pend_count_q <= '0;
      pending_q    <= 1'b0;
      overflow_q   <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_count_q   <= rd_count_d;
      pend_count_q <= pend_count_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      empty_done_q <= empty_done_d;
    end
  end

  scene_bank_ram #(
    .WIDTH  (DW),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_accept && wr_room),
    .waddr ({wr_bank_q, wr_ptr_q[AW-1:0]}),
    .wdata (bus.scene_in_data),
    .re    (ram_re),
    .raddr ({rd_bank_q, rd_addr_ptr}),
    .rdata (ram_rdata)
  );

  assign bus.scene_in_ready  = !pending_q;
  assign bus.scene_out_valid = (state_q == R_STREAM);
  assign bus.scene_out_data  = ram_rdata;
  assign bus.scene_out_last  = out_last;
  assign frame_done          = stream_done || empty_done_q;
  assign overflow            = overflow_q;

`ifdef SCENE_BUFFER_STATS_EN
  logic [15:0] frame_counter_q;

  always_ff @(posedge clk) begin
    if (!rstn)           frame_counter_q <= '0;
    else if (frame_done) frame_counter_q <= frame_counter_q + 16'd1;
  end

  assign committed_count = rd_count_q;
  assign frame_counter   = frame_counter_q;
`endif
endmodule

// File: tb/tb_scene_buffer.sv
// Self-checking bench for scene_buffer (MAX_INSTANCES=4): directed scenarios plus random traffic vs a queue model.
module tb_scene_buffer;
  import scene_buffer_pkg::*;

  localparam int MAXI = 4;

  logic clk, rstn, frame_start, frame_done, overflow;
`ifdef SCENE_BUFFER_STATS_EN
  logic [$clog2(MAXI+1)-1:0] committed_count;
  logic [15:0]               frame_counter;
`endif

  scene_buffer_if bus();

  scene_buffer #(.MAX_INSTANCES(MAXI)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overflow    (overflow)
`ifdef SCENE_BUFFER_STATS_EN
    ,
    .committed_count (committed_count),
    .frame_counter   (frame_counter)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: scenes as queues; reader timing as "one gap cycle, then index into the scene".
  modelinstance_t m_build[$];
  modelinstance_t m_cur[$];
  bit             m_pend, m_ovf, m_gap, m_done_next;
  int             m_idx = -1;
  logic [15:0]    m_frames;

  always @(negedge clk) begin
    bit ev, el, ed, xfer, pend_now;
    if (!rstn) begin
      m_build.delete();
      m_cur.delete();
      m_pend = 0; m_ovf = 0; m_gap = 0; m_done_next = 0; m_idx = -1; m_frames = '0;
    end else begin
      ev   = (m_idx >= 0);
      el   = ev && (m_idx == m_cur.size() - 1);
      xfer = ev && bus.scene_out_ready;
      ed   = m_done_next || (el && bus.scene_out_ready);
      chk("in_ready",   64'(bus.scene_in_ready),  64'(!m_pend));
      chk("out_valid",  64'(bus.scene_out_valid), 64'(ev));
      chk("out_last",   64'(bus.scene_out_last),  64'(el));
      chk("frame_done", 64'(frame_done),          64'(ed));
      chk("overflow",   64'(overflow),            64'(m_ovf));
      if (ev) chk("out_data", 64'(bus.scene_out_data), 64'(m_cur[m_idx]));
`ifdef SCENE_BUFFER_STATS_EN
      chk("frame_counter",   64'(frame_counter),   64'(m_frames));
      chk("committed_count", 64'(committed_count), 64'(m_cur.size()));
`endif
      if (xfer)
        $display("[TB] out  #%0d data=%08h last=%0b", m_idx, bus.scene_out_data, el);

      pend_now    = m_pend;
      m_done_next = 0;
      if (ev) begin
        if (xfer) begin
          if (el) m_idx = -1;
          else    m_idx++;
        end
      end else if (m_gap) begin
        m_gap = 0;
        m_idx = 0;
      end else if (frame_start) begin
        if (pend_now) begin
          m_cur = m_build;
          m_build.delete();
          m_pend = 0;
        end
        if (m_cur.size() == 0) m_done_next = 1;
        else                   m_gap = 1;
      end
      if (ed) m_frames = m_frames + 16'd1;

      if (bus.scene_in_valid && !pend_now) begin
        $display("[TB] in   data=%08h last=%0b %s", bus.scene_in_data,
                 bus.scene_in_metadata.last, (m_build.size() < MAXI) ? "stored" : "dropped");
        if (m_build.size() < MAXI) m_build.push_back(bus.scene_in_data);
        else                       m_ovf = 1;
        if (bus.scene_in_metadata.last) m_pend = 1;
      end
    end
  end

  // Directed helpers
  modelinstance_t col_words[$];
  bit             col_lasts[$];
  int             col_first;
  bit             col_done_ok;
  logic [31:0]    exp_q[$];

  task automatic push_word(input logic [31:0] w, input bit last);
    int t = 0;
    bus.scene_in_valid         = 1'b1;
    bus.scene_in_data          = modelinstance_t'(w);
    bus.scene_in_metadata.last = last;
    @(negedge clk);
    while (!bus.scene_in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("push timeout", 64'(bus.scene_in_ready), 64'(1));
    @(posedge clk); #1;
    bus.scene_in_valid         = 1'b0;
    bus.scene_in_metadata.last = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic collect_frame(input bit throttle);
    int         n = 0;
    logic [1:0] pat = '0;
    bit         done = 0;
    bit         saw_valid;
    bit [3:0]   tpat = 4'b1001;
    col_words.delete();
    col_lasts.delete();
    col_first   = -1;
    col_done_ok = 0;
    while (!done && n < 60) begin
      bus.scene_out_ready = throttle ? tpat[pat] : 1'b1;
      @(negedge clk);
      n++;
      saw_valid = bus.scene_out_valid;
      if (saw_valid && col_first < 0) col_first = n;
      if (saw_valid && bus.scene_out_ready) begin
        col_words.push_back(bus.scene_out_data);
        col_lasts.push_back(bus.scene_out_last);
        if (bus.scene_out_last && frame_done) col_done_ok = 1;
      end
      if (frame_done) done = 1;
      @(posedge clk); #1;
      if (saw_valid) pat = pat + 2'd1;
    end
    bus.scene_out_ready = 1'b1;
    if (!done) chk("frame timeout", 64'(done), 64'(1));
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " count"}, 64'(col_words.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < col_words.size(); i++) begin
      chk($sformatf("%s word%0d", tag, i), 64'(col_words[i]), 64'(exp_q[i]));
      chk($sformatf("%s last%0d", tag, i), 64'(col_lasts[i]), 64'(i == exp_q.size() - 1));
    end
    chk({tag, " done_on_last"}, 64'(col_done_ok), 64'(1));
  endtask

  localparam logic [31:0] W_A = 32'h0A_111_AAA;
  localparam logic [31:0] W_B = 32'h0B_222_BBB;
  localparam logic [31:0] W_C = 32'h0C_333_CCC;
  localparam logic [31:0] W_D = 32'h0D_444_DDD;
  localparam logic [31:0] W_E = 32'h0E_555_EEE;
  localparam logic [31:0] W_F = 32'h0F_666_FFF;
  localparam logic [31:0] W_O = 32'h40_000_100;

  initial begin
    int stall;
    rstn = 1'b0; frame_start = 1'b0;
    bus.scene_in_valid = 1'b0; bus.scene_in_data = '0; bus.scene_in_metadata = '0;
    bus.scene_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    chk("rst in_ready",  64'(bus.scene_in_ready),  64'(1));
    chk("rst out_valid", 64'(bus.scene_out_valid), 64'(0));
    chk("rst out_last",  64'(bus.scene_out_last),  64'(0));
    chk("rst done",      64'(frame_done),          64'(0));
    chk("rst overflow",  64'(overflow),            64'(0));
    chk("rst out_data",  64'(bus.scene_out_data),  64'(0));
    @(posedge clk); #1;

    // Frame with nothing committed: done one cycle later, no data.
    frame_start = 1'b1;
    @(negedge clk);
    chk("empty done early", 64'(frame_done), 64'(0));
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("empty done pulse", 64'(frame_done),          64'(1));
    chk("empty no valid",   64'(bus.scene_out_valid), 64'(0));
    @(negedge clk);
    chk("empty done once",  64'(frame_done),          64'(0));
    @(posedge clk); #1;

    push_word(W_A, 0); push_word(W_B, 0); push_word(W_C, 1);
    pulse_frame();
    collect_frame(0);
    chk("abc first_valid", 64'(col_first), 64'(2));
    exp_q = '{W_A, W_B, W_C};
    check_frame("abc");

    // F must wait behind the committed D,E scene until the swap.
    push_word(W_D, 0); push_word(W_E, 1);
    bus.scene_in_valid = 1'b1; bus.scene_in_data = modelinstance_t'(W_F); bus.scene_in_metadata.last = 1'b0;
    stall = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.scene_in_ready) stall++;
      @(posedge clk); #1;
    end
    chk("F stalled", 64'(stall), 64'(0));
    pulse_frame();
    @(negedge clk);
    chk("F accepted after swap", 64'(bus.scene_in_ready), 64'(1));
    @(posedge clk); #1;
    bus.scene_in_valid = 1'b0;
    collect_frame(0);
    exp_q = '{W_D, W_E};
    check_frame("de");

    pulse_frame();
    collect_frame(1);
    check_frame("de restream throttled");

    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) push_word(W_O + 32'(i), 0);
    @(negedge clk);
    chk("ovf not yet", 64'(overflow), 64'(0));
    @(posedge clk); #1;
    push_word(W_O + 32'd4, 0);
    @(negedge clk);
    chk("ovf set",          64'(overflow),           64'(1));
    chk("ovf ready stays",  64'(bus.scene_in_ready), 64'(1));
    @(posedge clk); #1;
    push_word(W_O + 32'd5, 1);
    pulse_frame();
    collect_frame(0);
    exp_q = '{W_O, W_O + 32'd1, W_O + 32'd2, W_O + 32'd3};
    check_frame("ovf");

    for (int c = 0; c < 1500; c++) begin
      rstn                       = ($urandom_range(0, 299) != 0);
      bus.scene_in_valid         = 1'($urandom_range(0, 1));
      bus.scene_in_data          = modelinstance_t'($urandom);
      bus.scene_in_metadata.last = ($urandom_range(0, 4) == 0);
      frame_start                = ($urandom_range(0, 9) == 0);
      bus.scene_out_ready        = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rstn = 1'b1; frame_start = 1'b0; bus.scene_in_valid = 1'b0; bus.scene_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scene_buffer.md
Name: scene_buffer

Overview:
Double-buffered (ping-pong) store for scene model instances, directly downstream of the command decoder's scene stream. It accepts modelinstance_t words until one is flagged last, then commits that scene. On each renderer frame_start it swaps in the newest committed scene and streams it out in order. The command side can build scene N+1 while the renderer walks scene N.

Parameters:
MAX_INSTANCES, 64, entries per bank; power of two, minimum 2.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
scene_in_valid  in  1  writer handshake valid
scene_in_ready  out  1  writer handshake ready
scene_in_data  in  $bits(modelinstance_t)  instance to store
scene_in_metadata  in  $bits(modelinstance_meta_t)  .last marks the final instance of the scene
frame_start  in  1  single-cycle pulse from renderer requesting the next frame's instances
scene_out_valid  out  1  reader handshake valid
scene_out_ready  in  1  reader handshake ready
scene_out_data  out  $bits(modelinstance_t)  instance to renderer
scene_out_last  out  1  high with the final instance of the frame
frame_done  out  1  one-cycle pulse when the frame stream is finished
overflow  out  1  sticky; a scene exceeded MAX_INSTANCES

Behaviour:
- Reset (rstn low at posedge clk): wr_bank=0, rd_bank=1, wr_ptr=0, rd_count=0, pending=0, reader in R_IDLE.
- Reset output values: scene_in_ready=1, scene_out_valid=0, scene_out_last=0, frame_done=0, overflow=0, scene_out_data=0.
- Reset mid-stream discards both banks; no partial frame resumes.
- Write side:
  - scene_in_ready = !pending.
  - On each accepted word with wr_ptr<MAX_INSTANCES: store at [wr_bank][wr_ptr], then wr_ptr++.
  - On an accepted word with last=1: pending<=1 and pending_count<=stored count (including that word); wr_ptr is cleared at the swap.
- Overflow:
  - Accepted words arriving when wr_ptr==MAX_INSTANCES are dropped and set overflow=1.
  - Ready stays high during overflow so the command path never deadlocks.
  - A dropped word that has last=1 still commits, with pending_count=MAX_INSTANCES.
- Reader FSM, three states: R_IDLE, R_FETCH, R_STREAM.
  - R_IDLE + frame_start: if pending, swap banks (rd_bank<=wr_bank, wr_bank<=rd_bank, rd_count<=pending_count, pending<=0, wr_ptr<=0). Otherwise re-stream the current read bank (scene persists across frames).
  - Then: if the effective count is 0, pulse frame_done next cycle and stay in R_IDLE. Otherwise set rd_ptr=0 and go to R_FETCH.
  - R_FETCH: issue synchronous RAM read; go to R_STREAM. First scene_out_valid is 2 cycles after frame_start.
  - R_STREAM: output is registered; data and last are held stable while valid && !ready.
  - On each transfer, the next word is presented the following cycle, so sustained ready gives back-to-back output.
  - scene_out_last=1 when rd_ptr==rd_count-1.
  - On the last transfer: valid drops, frame_done pulses in the same cycle as the transfer, and the FSM returns to R_IDLE.
  - frame_start outside R_IDLE is ignored.
- Simultaneous events:
  - A last word accepted in the same cycle as frame_start does not swap. The swap decision uses the registered pending, so that scene is picked up at the next frame_start.
  - A swap and a write never collide: the write is blocked while pending=1.
- Widths: pointers and counts are $clog2(MAX_INSTANCES+1) bits; no wrap. wr_ptr saturates at MAX_INSTANCES.

Optional Feature:
- Macro SCENE_BUFFER_STATS_EN.
- Defined: adds output ports committed_count (count width, equal to rd_count) and frame_counter (16 bits).
  - frame_counter increments on each frame_done, wraps 0xFFFF->0, and resets to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to types_pkg: localparam SCENE_MAX_INSTANCES=64; typedef scene_idx_t (count width).
- Reuse the existing modelinstance_t and modelinstance_meta_t.
- Sub-module scene_bank_ram: simple dual-port synchronous RAM, depth 2*MAX_INSTANCES.
  - Write address {wr_bank,wr_ptr}; read address {rd_bank,rd_ptr}; 1-cycle read latency.

Test Plan:
- Reset, frame_start with no scene -> no scene_out_valid; frame_done pulses exactly 1 cycle later.
- Write 3 instances A,B,C (C last=1), then frame_start -> A,B,C out back-to-back, last only on C, frame_done on C's transfer; first valid 2 cycles after frame_start.
- Write scene D,E (E last), then write F before any frame_start -> F stalls with scene_in_ready=0 until frame_start. Next frame streams D,E, then F is accepted.
- Second frame_start with nothing pending -> D,E re-streamed unchanged.
- Throttle: scene_out_ready toggles 1,0,0,1 during streaming -> data held stable; no duplicated or skipped instances.
- Overflow with MAX_INSTANCES=4: write 6 words, last on the 6th -> overflow=1; frame streams the first 4 words, with last on the 4th.
